ap_ptr_file: RTL and testbench



---
 rtl/ap_ptr_file.sv | 124 ++++++++++++
 tb/tb_ap_ptr_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ap_ptr_file.sv
// Address-pointer register file: one pointer operation per cycle on the entry picked by APSel,
// with a registered effective address, zero flag and out-of-range select flag.
module ap_ptr_file #(
    parameter int ADDR_W   = 16,
    parameter int NUM_AP   = 16,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          APSel,
    input  logic                op_valid,
    input  logic [1:0]          op,
    input  logic [ADDR_W-1:0]   load_data,
    input  logic [STRIDE_W-1:0] stride,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                addr_valid,
    output logic                zero,
    output logic                sel_err
);

    localparam int IDX_W = (NUM_AP > 1) ? $clog2(NUM_AP) : 1;
    localparam logic [4:0] NUM_AP_L = 5'(NUM_AP);

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_LOAD    = 2'b01,
        OP_POSTINC = 2'b10,
        OP_PREDEC  = 2'b11
    } op_e;

    logic [ADDR_W-1:0] ptr [NUM_AP];

    logic              sel_ok;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              wr_en;
    op_e               op_q;

    assign sel_ok = ({1'b0, APSel} < NUM_AP_L);
    assign idx    = APSel[IDX_W-1:0];
    assign op_q   = op_e'(op);

    // Stride of zero means a unit step so software never stalls a pointer by accident.
    assign step = (stride == '0) ? ADDR_W'(1) : ADDR_W'(stride);

    always_comb begin
        cur      = '0;
        ptr_nxt  = '0;
        addr_nxt = '0;
        wr_en    = 1'b0;
        if (sel_ok) begin
            cur = ptr[idx];
        end
        case (op_q)
            OP_READ: begin
                ptr_nxt  = cur;
                addr_nxt = cur;
            end
            OP_LOAD: begin
                ptr_nxt  = load_data;
                addr_nxt = load_data;
                wr_en    = 1'b1;
            end
            OP_POSTINC: begin
                ptr_nxt  = cur + step;
                addr_nxt = cur;
                wr_en    = 1'b1;
            end
            OP_PREDEC: begin
                ptr_nxt  = cur - step;
                addr_nxt = cur - step;
                wr_en    = 1'b1;
            end
            default: begin
                ptr_nxt  = cur;
                addr_nxt = cur;
            end
        endcase
        if (!op_valid || !sel_ok) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AP; i++) begin
                ptr[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_AP; i++) begin
                if (idx == IDX_W'(i)) begin
                    ptr[i] <= ptr_nxt;
                end
            end
        end
    end

    // Outputs hold across idle cycles; only addr_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out   <= '0;
            addr_valid <= 1'b0;
            zero       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            addr_valid <= op_valid;
            if (op_valid) begin
                if (sel_ok) begin
                    addr_out <= addr_nxt;
                    zero     <= (ptr_nxt == '0);
                    sel_err  <= 1'b0;
                end else begin
                    addr_out <= '0;
                    zero     <= 1'b0;
                    sel_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ap_ptr_file.sv
// Bench for ap_ptr_file: two instances (16 and 8 pointers) driven in lockstep and compared
// against an array-based reference model, with directed scenarios plus random traffic.
module tb_ap_ptr_file;

    localparam logic [1:0] RD = 2'b00, LD = 2'b01, PI = 2'b10, PD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  APSel;
    logic        op_valid;
    logic [1:0]  op;
    logic [15:0] load_data;
    logic [3:0]  stride;

    logic [15:0] aout0, aout1;
    logic        aval0, aval1, zr0, zr1, err0, err1;

    int total = 0;
    int bad   = 0;

    logic [15:0] mptr [2][16];
    logic [15:0] e_addr [2];
    logic        e_val [2];
    logic        e_zero [2];
    logic        e_err [2];
    int          nap [2];

    always #5 clk = ~clk;

    ap_ptr_file #(.ADDR_W(16), .NUM_AP(16), .STRIDE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .APSel(APSel), .op_valid(op_valid), .op(op),
        .load_data(load_data), .stride(stride),
        .addr_out(aout0), .addr_valid(aval0), .zero(zr0), .sel_err(err0)
    );

    ap_ptr_file #(.ADDR_W(16), .NUM_AP(8), .STRIDE_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .APSel(APSel), .op_valid(op_valid), .op(op),
        .load_data(load_data), .stride(stride),
        .addr_out(aout1), .addr_valid(aval1), .zero(zr1), .sel_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mptr[k][i] = '0;
            e_addr[k] = '0;
            e_val[k]  = 1'b0;
            e_zero[k] = 1'b0;
            e_err[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input int sel, input logic [1:0] o,
                              input logic [15:0] ld, input logic [3:0] st);
        int s;
        logic [15:0] p, np, a;
        s = (st == 0) ? 1 : int'(st);
        for (int k = 0; k < 2; k++) begin
            e_val[k] = v;
            if (!v) continue;
            if (sel >= nap[k]) begin
                e_addr[k] = '0;
                e_zero[k] = 1'b0;
                e_err[k]  = 1'b1;
                continue;
            end
            p = mptr[k][sel];
            case (o)
                RD: begin np = p;                   a = p;  end
                LD: begin np = ld;                  a = ld; end
                PI: begin np = 16'((p + s) % 65536); a = p; end
                default: begin np = 16'((int'(p) + 65536 - s) % 65536); a = np; end
            endcase
            mptr[k][sel] = np;
            e_addr[k] = a;
            e_zero[k] = (np == 0);
            e_err[k]  = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk($sformatf("%s.u0.addr", tag), 32'(aout0), 32'(e_addr[0]));
        chk($sformatf("%s.u0.val", tag),  32'(aval0), 32'(e_val[0]));
        chk($sformatf("%s.u0.zero", tag), 32'(zr0),   32'(e_zero[0]));
        chk($sformatf("%s.u0.err", tag),  32'(err0),  32'(e_err[0]));
        chk($sformatf("%s.u1.addr", tag), 32'(aout1), 32'(e_addr[1]));
        chk($sformatf("%s.u1.val", tag),  32'(aval1), 32'(e_val[1]));
        chk($sformatf("%s.u1.zero", tag), 32'(zr1),   32'(e_zero[1]));
        chk($sformatf("%s.u1.err", tag),  32'(err1),  32'(e_err[1]));
    endtask

    // Called just after a rising edge; returns just after the next one with outputs checked.
    task automatic do_op(input string tag, input logic v, input int sel, input logic [1:0] o,
                         input logic [15:0] ld, input logic [3:0] st);
        op_valid  = v;
        APSel     = 4'(sel);
        op        = o;
        load_data = ld;
        stride    = st;
        @(posedge clk);
        model_step(v, sel, o, ld, st);
        #1;
        check_outs(tag);
    endtask

    initial begin
        nap[0] = 16;
        nap[1] = 8;
        rst_n = 1'b0;
        op_valid = 1'b0; APSel = '0; op = RD; load_data = '0; stride = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("por");
        rst_n = 1'b1;

        // Reset mid-stream
        do_op("ld3", 1, 3, LD, 16'h1234, 0);
        chk("ld3.addr_const", 32'(aout0), 32'h1234);
        APSel = 4'd3; op = LD; load_data = 16'h5555; op_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        op_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_op("rd3_after_rst", 1, 3, RD, 0, 0);
        chk("rd3.zero_const", 32'(zr0), 32'h1);

        // LOAD then POSTINC stride 4
        do_op("ld5", 1, 5, LD, 16'h00F0, 0);
        do_op("pi5a", 1, 5, PI, 0, 4);
        chk("pi5a.const", 32'(aout0), 32'h00F0);
        do_op("pi5b", 1, 5, PI, 0, 4);
        chk("pi5b.const", 32'(aout0), 32'h00F4);
        do_op("pi5c", 1, 5, PI, 0, 4);
        chk("pi5c.const", 32'(aout0), 32'h00F8);
        do_op("rd5", 1, 5, RD, 0, 0);
        chk("rd5.const", 32'(aout0), 32'h00FC);

        // PREDEC wrap with stride 0
        do_op("ld0", 1, 0, LD, 16'h0001, 0);
        do_op("pd0a", 1, 0, PD, 0, 0);
        chk("pd0a.const", 32'(aout0), 32'h0000);
        chk("pd0a.zero_const", 32'(zr0), 32'h1);
        do_op("pd0b", 1, 0, PD, 0, 0);
        chk("pd0b.const", 32'(aout0), 32'hFFFF);
        chk("pd0b.zero_const", 32'(zr0), 32'h0);

        // POSTINC wrap at the top
        do_op("ldtop", 1, 7, LD, 16'hFFFF, 0);
        do_op("pitop", 1, 7, PI, 0, 1);
        do_op("rdtop", 1, 7, RD, 0, 0);
        chk("rdtop.const", 32'(aout0), 32'h0000);

        // Walk 0..8, then read all; POSTINC ptr2 must not touch neighbours
        for (int i = 0; i <= 8; i++) do_op($sformatf("walk_ld%0d", i), 1, i, LD, 16'(i * 256), 0);
        for (int i = 0; i <= 8; i++) begin
            do_op($sformatf("walk_rd%0d", i), 1, i, RD, 0, 0);
            chk($sformatf("walk_rd%0d.const", i), 32'(aout0), 32'(i * 256));
        end
        do_op("pi2", 1, 2, PI, 0, 3);
        do_op("iso1", 1, 1, RD, 0, 0);
        chk("iso1.const", 32'(aout0), 32'h0100);
        do_op("iso3", 1, 3, RD, 0, 0);
        chk("iso3.const", 32'(aout0), 32'h0300);

        // Invalid index on the 8-entry instance
        do_op("bad9", 1, 9, LD, 16'hBEEF, 0);
        chk("bad9.err_const", 32'(err1), 32'h1);
        chk("bad9.addr_const", 32'(aout1), 32'h0);
        for (int i = 0; i < 8; i++) do_op($sformatf("bad9_rd%0d", i), 1, i, RD, 0, 0);
        do_op("bad9b", 1, 9, RD, 0, 0);
        do_op("ok2", 1, 2, RD, 0, 0);
        chk("ok2.err_const", 32'(err1), 32'h0);

        // Idle hold after POSTINC
        do_op("pi_idle", 1, 4, PI, 0, 5);
        for (int i = 0; i < 5; i++) do_op($sformatf("idle%0d", i), 0, 4, LD, 16'hDEAD, 7);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            do_op($sformatf("rnd%0d", n), ($urandom_range(0, 9) < 8), $urandom_range(0, 15),
                  2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
